// File: rtl/keystream_xor_unit.sv
// keystream_xor_unit
//   Datapath stage behind counter_block. It holds the counter register that
//   feeds counter_block's prev_value and drives that block's controls. Each
//   accepted plaintext word is combined with counter_next and key, run through
//   an iterative ARX mix, and XORed with the keystream. The result is a
//   registered ciphertext word.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   key             cipher key, held stable per message (shared with counter_block)
//   valid_in        plaintext word valid
//   new_message     first word of a message (qualifies valid_in)
//   data_in         plaintext word
//   ready_in        combinational accept indicator, high only in IDLE
//   counter_in      counter_block counter_next
//   counter_reg     registered counter, drives counter_block prev_value
//   cb_enable       counter_block enable (valid_in & ready_in)
//   cb_new_message  counter_block new_message (pass-through)
//   data_out        ciphertext word
//   valid_out       data_out valid
//   ready_out       downstream accepts data_out

module keystream_xor_unit #(
    parameter int unsigned ROUNDS = 4,
    parameter int unsigned ROT    = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] key,
    input  logic        valid_in,
    input  logic        new_message,
    input  logic [31:0] data_in,
    output logic        ready_in,
    input  logic [31:0] counter_in,
    output logic [31:0] counter_reg,
    output logic        cb_enable,
    output logic        cb_new_message,
    output logic [31:0] data_out,
    output logic        valid_out,
    input  logic        ready_out
);

    localparam int unsigned W  = 32;
    localparam int unsigned RW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    s;
    logic [W-1:0]    data_lat;
    logic [RW-1:0]   round;

    logic [W-1:0]    sum_c;
    logic [W-1:0]    rot_c;
    logic [W-1:0]    s_next_c;
    logic            last_round_c;

    // One ARX round: add key, rotate left by ROT, mix in the round index
    assign sum_c        = s + key;
    assign rot_c        = (sum_c << ROT) | (sum_c >> (W - ROT));
    assign s_next_c     = rot_c ^ {{(W-RW){1'b0}}, round};
    assign last_round_c = (round == RW'(ROUNDS - 1));

    // Handshake and counter_block controls; ready_in is forced low during reset
    assign ready_in       = (state == IDLE) && !rst;
    assign cb_enable      = valid_in & ready_in;
    assign cb_new_message = new_message;

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            counter_reg <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            round       <= '0;
            s           <= '0;
            data_lat    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        counter_reg <= counter_in;
                        s           <= counter_in ^ key;
                        data_lat    <= data_in;
                        round       <= '0;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    s     <= s_next_c;
                    round <= round + RW'(1);
                    if (last_round_c) begin
                        data_out  <= data_lat ^ s_next_c;
                        valid_out <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Output is held until the consumer takes it
                    if (ready_out) begin
                        valid_out <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keystream_xor_unit.sv
// Bench for keystream_xor_unit: instance 0 uses ROUNDS=1, instance 1 uses the
// default parameters. A behavioural counter_block sits in front of each instance.
module tb_keystream_xor_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst[2];
    logic        valid_in[2];
    logic        new_message[2];
    logic        ready_in[2];
    logic        cb_enable[2];
    logic        cb_new_message[2];
    logic        valid_out[2];
    logic        ready_out[2];
    logic        force_en[2];
    logic [31:0] key[2];
    logic [31:0] data_in[2];
    logic [31:0] counter_in[2];
    logic [31:0] counter_reg[2];
    logic [31:0] data_out[2];
    logic [31:0] force_val[2];

    logic [31:0] exp_ctr[2];
    int n_checks = 0;
    int n_fail   = 0;

    // counter_block behaviour, with an override used to force counter values
    assign counter_in[0] = force_en[0] ? force_val[0] :
                           (cb_new_message[0] ? key[0] : counter_reg[0] + 32'd1);
    assign counter_in[1] = force_en[1] ? force_val[1] :
                           (cb_new_message[1] ? key[1] : counter_reg[1] + 32'd1);

    keystream_xor_unit #(.ROUNDS(1), .ROT(7)) u_r1 (
        .clk(clk), .rst(rst[0]), .key(key[0]), .valid_in(valid_in[0]),
        .new_message(new_message[0]), .data_in(data_in[0]), .ready_in(ready_in[0]),
        .counter_in(counter_in[0]), .counter_reg(counter_reg[0]),
        .cb_enable(cb_enable[0]), .cb_new_message(cb_new_message[0]),
        .data_out(data_out[0]), .valid_out(valid_out[0]), .ready_out(ready_out[0])
    );

    keystream_xor_unit u_r4 (
        .clk(clk), .rst(rst[1]), .key(key[1]), .valid_in(valid_in[1]),
        .new_message(new_message[1]), .data_in(data_in[1]), .ready_in(ready_in[1]),
        .counter_in(counter_in[1]), .counter_reg(counter_reg[1]),
        .cb_enable(cb_enable[1]), .cb_new_message(cb_new_message[1]),
        .data_out(data_out[1]), .valid_out(valid_out[1]), .ready_out(ready_out[1])
    );

    function automatic int unsigned rounds_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    // Keystream from the round rule, rotate amount 7
    function automatic logic [31:0] ref_ks(input logic [31:0] ctr, input logic [31:0] k,
                                           input int unsigned rounds);
        logic [31:0] st;
        logic [31:0] t;
        st = ctr ^ k;
        for (int unsigned r = 0; r < rounds; r++) begin
            t  = st + k;
            st = ((t << 7) | (t >> 25)) ^ (r & 32'hFF);
        end
        return st;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one word and let it be accepted; returns the modelled ciphertext
    task automatic send(input int d, input logic [31:0] data, input logic nm,
                        input logic fen, input logic [31:0] fval,
                        output logic [31:0] exp_out);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!ready_in[d] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check_eq("ready_in_before_send", 32'(ready_in[d]), 32'd1);
        force_en[d]    = fen;
        force_val[d]   = fval;
        valid_in[d]    = 1'b1;
        data_in[d]     = data;
        new_message[d] = nm;
        #1;
        check_eq("cb_enable_on_accept", 32'(cb_enable[d]), 32'd1);
        check_eq("cb_new_message", 32'(cb_new_message[d]), 32'(nm));
        exp_ctr[d] = fen ? fval : (nm ? key[d] : exp_ctr[d] + 32'd1);
        exp_out    = data ^ ref_ks(exp_ctr[d], key[d], rounds_of(d));
        @(posedge clk);
        #1;
        valid_in[d]    = 1'b0;
        new_message[d] = 1'b0;
        force_en[d]    = 1'b0;
        check_eq("counter_reg_after_accept", counter_reg[d], exp_ctr[d]);
        check_eq("ready_in_low_in_run", 32'(ready_in[d]), 32'd0);
    endtask

    // Wait for the result, hold it for 'hold' cycles with stray input pulses, then take it
    task automatic collect(input int d, input logic [31:0] exp_out, input int hold);
        int lat;
        lat = 0;
        while (!valid_out[d] && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(rounds_of(d)));
        check_eq("data_out", data_out[d], exp_out);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            valid_in[d]    = 1'($urandom % 2);
            new_message[d] = 1'($urandom % 2);
            data_in[d]     = $urandom;
            #1;
            check_eq("hold_ready_in", 32'(ready_in[d]), 32'd0);
            check_eq("hold_cb_enable", 32'(cb_enable[d]), 32'd0);
            @(posedge clk);
            #1;
            check_eq("hold_valid_out", 32'(valid_out[d]), 32'd1);
            check_eq("hold_data_out", data_out[d], exp_out);
            check_eq("hold_counter_reg", counter_reg[d], exp_ctr[d]);
        end
        @(negedge clk);
        valid_in[d]    = 1'b0;
        new_message[d] = 1'b0;
        ready_out[d]   = 1'b1;
        @(posedge clk);
        #1;
        ready_out[d] = 1'b0;
        check_eq("valid_out_cleared", 32'(valid_out[d]), 32'd0);
        check_eq("ready_in_back_idle", 32'(ready_in[d]), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] e;
        logic [31:0] q[$];
        int acc_cyc[$];
        int outs;

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; valid_in[d] = 1'b0; new_message[d] = 1'b0;
            data_in[d] = '0; ready_out[d] = 1'b0; force_en[d] = 1'b0;
            force_val[d] = '0; key[d] = 32'hADACABAA; exp_ctr[d] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq("rst_valid_out", 32'(valid_out[d]), 32'd0);
            check_eq("rst_data_out", data_out[d], 32'd0);
            check_eq("rst_counter_reg", counter_reg[d], 32'd0);
            check_eq("rst_ready_in", 32'(ready_in[d]), 32'd0);
        end
        @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;
        #1;
        check_eq("ready_in_after_rst", 32'(ready_in[0]), 32'd1);

        // Directed vectors, ROUNDS=1
        send(0, 32'h00000000, 1'b1, 1'b0, 32'h0, e);
        check_eq("tp1_counter", counter_reg[0], 32'hADACABAA);
        collect(0, 32'hD655D556, 0);
        send(0, 32'h00000000, 1'b0, 1'b0, 32'h0, e);
        check_eq("tp2_counter", counter_reg[0], 32'hADACABAB);
        collect(0, 32'hD655D5D6, 0);
        send(0, 32'hD655D556, 1'b1, 1'b0, 32'h0, e);
        check_eq("tp3_counter", counter_reg[0], 32'hADACABAA);
        collect(0, 32'h00000000, 0);

        // Counter wrap, key=1
        key[0] = 32'h00000001;
        send(0, $urandom, 1'b1, 1'b1, 32'hFFFFFFFF, e);
        check_eq("wrap_counter_max", counter_reg[0], 32'hFFFFFFFF);
        collect(0, e, 1);
        send(0, $urandom, 1'b0, 1'b0, 32'h0, e);
        check_eq("wrap_counter_zero", counter_reg[0], 32'h00000000);
        collect(0, e, 0);

        // Random messages on both instances
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 15; i++) begin
                logic nm;
                nm = (i == 0) || ($urandom % 4 == 0);
                if (nm) key[d] = $urandom;
                send(d, $urandom, nm, 1'b0, 32'h0, e);
                collect(d, e, int'($urandom_range(0, 3)));
            end
        end

        // Back-pressure for 10 cycles, default parameters
        send(1, $urandom, 1'b0, 1'b0, 32'h0, e);
        collect(1, e, 10);

        // Reset during RUN discards the word
        send(1, $urandom, 1'b0, 1'b0, 32'h0, e);
        @(negedge clk);
        rst[1] = 1'b1;
        #1;
        check_eq("ready_in_during_rst", 32'(ready_in[1]), 32'd0);
        @(posedge clk);
        #1;
        check_eq("run_rst_valid_out", 32'(valid_out[1]), 32'd0);
        check_eq("run_rst_counter", counter_reg[1], 32'd0);
        @(negedge clk);
        rst[1] = 1'b0;
        exp_ctr[1] = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check_eq("no_output_after_rst", 32'(valid_out[1]), 32'd0);
        end

        // Throughput with ready_out tied high
        key[1] = $urandom;
        ready_out[1] = 1'b1;
        outs = 0;
        @(negedge clk);
        data_in[1] = $urandom;
        new_message[1] = 1'b1;
        valid_in[1] = 1'b1;
        #1;
        for (int c = 0; c < 50; c++) begin
            logic acc;
            if (c == 40) begin
                valid_in[1] = 1'b0;
                #1;
            end
            acc = cb_enable[1];
            if (acc) begin
                exp_ctr[1] = new_message[1] ? key[1] : exp_ctr[1] + 32'd1;
                q.push_back(data_in[1] ^ ref_ks(exp_ctr[1], key[1], rounds_of(1)));
                acc_cyc.push_back(c);
            end
            @(posedge clk);
            #1;
            if (acc) begin
                data_in[1] = $urandom;
                new_message[1] = 1'b0;
                check_eq("tput_counter_reg", counter_reg[1], exp_ctr[1]);
            end
            if (valid_out[1]) begin
                outs++;
                if (q.size() > 0) check_eq("tput_data_out", data_out[1], q.pop_front());
                else check_eq("tput_unexpected_output", 32'(valid_out[1]), 32'd0);
            end
            @(negedge clk);
            #1;
        end
        ready_out[1] = 1'b0;
        check_eq("tput_pending", 32'(q.size()), 32'd0);
        check_eq("tput_accepts", 32'(acc_cyc.size()), 32'd7);
        check_eq("tput_outputs", 32'(outs), 32'd7);
        for (int i = 1; i < acc_cyc.size(); i++)
            check_eq("tput_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(rounds_of(1) + 2));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keystream_xor_unit.md
Name: keystream_xor_unit

Overview:
Datapath stage directly downstream of counter_block. It owns the counter register that feeds counter_block's prev_value and drives its enable and new_message controls. For each accepted plaintext word it consumes counter_next, runs an iterative ARX keystream mix keyed by key, and emits data_in XOR keystream as a registered ciphertext word. Input and output both use valid/ready handshakes.

Parameters:
ROUNDS, 4, number of mix rounds per word; legal range 1..255.
ROT, 7, left-rotate amount per round; legal range 1..31.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
key  input  32  cipher key; must be held stable for the whole message; also wired to counter_block key
valid_in  input  1  plaintext word valid
new_message  input  1  qualifies valid_in; marks the first word of a message
data_in  input  32  plaintext word
ready_in  output  1  block can accept a word (combinational, high only in IDLE)
counter_in  input  32  counter_block counter_next
counter_reg  output  32  registered counter; drives counter_block prev_value
cb_enable  output  1  to counter_block enable; equals valid_in & ready_in
cb_new_message  output  1  to counter_block new_message; equals new_message
data_out  output  32  ciphertext word
valid_out  output  1  data_out valid
ready_out  input  1  downstream accepts data_out

Behaviour:
- Reset values (rst sampled high at a clk edge): state=IDLE, counter_reg=0, data_out=0, valid_out=0, round counter=0, internal state s=0, latched data=0. ready_in=0 while rst is high.
- Accept: a word is accepted when valid_in & ready_in is high at a clk edge. On that edge:
  - counter_reg <= counter_in
  - s <= counter_in ^ key
  - latch data_in
  - round <= 0
  - state <= RUN
- Round function (mod 2^32): s_next = rotl32(s + key, ROT) ^ {24'b0, round[7:0]}.
- RUN state: each edge applies one round and increments round. The edge that applies round ROUNDS-1 also does:
  - data_out <= latched data ^ s_next
  - valid_out <= 1
  - state <= DONE
- DONE state: valid_out=1. data_out is held stable until ready_out is high at an edge; that edge clears valid_out and sets state to IDLE.
- Latency and throughput:
  - valid_out rises ROUNDS edges after the accept edge.
  - With ready_out tied high, one word is accepted every ROUNDS+2 cycles.
  - There is no bypass: ready_in stays low in RUN and DONE, even while ready_out is high.
- counter_reg changes only on accept edges or reset. cb_enable and cb_new_message are purely combinational, so counter_block produces key on the first word of a message and counter_reg+1 on subsequent words.
- new_message is ignored when valid_in is low.
- valid_in high outside IDLE: ignored, no state change. The upstream source must hold the word until ready_in is high.
- ready_out high in IDLE or RUN: no effect.
- rst asserted in RUN or DONE: the in-flight word is discarded, valid_out drops on that edge, counter_reg is set to 0, and the next word must carry new_message=1.
- Arithmetic wraps silently: s + key wraps mod 2^32, and the counter wraps 0xFFFFFFFF to 0x00000000 with no flag.

Test Plan:
- ROUNDS=1, ROT=7, key=ADACABAA, counter_block connected; word 1 data_in=00000000 with new_message=1 -> counter_reg=ADACABAA, data_out=D655D556, valid_out rises 1 edge after accept.
- Same setup; word 2 data_in=00000000 with new_message=0 -> counter_reg=ADACABAB, data_out=D655D5D6.
- Same setup; word 1 repeated with data_in=D655D556 and new_message=1 -> data_out=00000000, which confirms the XOR path and the counter restart to key.
- Default parameters, ready_out held low for 10 cycles after valid_out rises -> data_out stable, valid_out stays 1, ready_in stays 0, valid_in pulses ignored, counter_reg unchanged; release ready_out -> IDLE next edge.
- Default parameters, rst pulsed in the cycle after accept (RUN) -> next edge valid_out=0, counter_reg=00000000; no output word appears for the discarded input.
- ROUNDS=1, key=00000001, counter_reg forced via a word with counter_in=FFFFFFFF then next word with new_message=0 -> counter_reg=00000000 (wrap); data_out matches the bench's reference model for both words.
